// File: rtl/alsu_param_if.sv
// alsu_param_if: handshake and data bundle for alsu_param.
//   in_valid/in_ready : operation offer / acceptance (accept = in_valid && in_ready)
//   A, B              : signed WIDTH-bit operands
//   opcode            : 0 OR, 1 XOR, 2 ADD, 3 MUL, 4 SHIFT, 5 ROTATE, 6/7 invalid
//   cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B : control bits
//   shamt             : shift/rotate step count
//   out, out_valid    : signed 2*WIDTH-bit result and its one-cycle completion pulse
//   leds              : invalid-operation indicator
// Modport master drives the operation side; modport slave is the ALSU.
interface alsu_param_if #(
  parameter int WIDTH = 3,
  parameter int LED_W = 16
);
  localparam int OUT_W = 2 * WIDTH;
  localparam int SH_W  = $clog2(OUT_W);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic [2:0]              opcode;
  logic                    cin;
  logic                    serial_in;
  logic                    direction;
  logic                    red_op_A;
  logic                    red_op_B;
  logic                    bypass_A;
  logic                    bypass_B;
  logic [SH_W-1:0]         shamt;
  logic signed [OUT_W-1:0] out;
  logic                    out_valid;
  logic [LED_W-1:0]        leds;

  modport master (
    output in_valid, A, B, opcode, cin, serial_in, direction,
           red_op_A, red_op_B, bypass_A, bypass_B, shamt,
    input  in_ready, out, out_valid, leds
  );

  modport slave (
    input  in_valid, A, B, opcode, cin, serial_in, direction,
           red_op_A, red_op_B, bypass_A, bypass_B, shamt,
    output in_ready, out, out_valid, leds
  );
endinterface

// File: rtl/alsu_param.sv
// alsu_param: parametrised, handshaked ALSU.
// Ports:
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset
//   bus (slave)    : alsu_param_if carrying the handshake, operands, controls,
//                    result register, completion pulse and LED indicator
// Operations are captured on accept, then finish in EXEC (one edge), ITER
// (one shift/rotate step per edge, shamt edges) or, when the macro
// ALSU_PARAM_SERIAL_MULT_EN is defined, MUL (WIDTH-edge shift-add multiply).
// Without the macro the multiply is a single-cycle combinational product.
module alsu_param #(
  parameter int    WIDTH          = 3,
  parameter int    LED_W          = 16,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic       clk,
  input  logic       rst,
  alsu_param_if.slave bus
);
  localparam int OUT_W  = 2 * WIDTH;
  localparam int SH_W   = $clog2(OUT_W);
  localparam bit PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit ADD_CI = (FULL_ADDER == "ON");

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER
`ifdef ALSU_PARAM_SERIAL_MULT_EN
    ,
    MUL
`endif
  } state_t;

  state_t                  state_q;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic [2:0]              op_q;
  logic                    cin_q, sin_q, dir_q;
  logic                    ra_q, rb_q, ba_q, bb_q;
  logic [SH_W-1:0]         cnt_q;
  logic signed [OUT_W-1:0] out_q;
  logic                    vld_q;
  logic [LED_W-1:0]        leds_q;

`ifdef ALSU_PARAM_SERIAL_MULT_EN
  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] mcand_q;
  logic [WIDTH-1:0]        mplier_q;
  logic signed [OUT_W-1:0] mul_sum_d;
`endif

  logic signed [OUT_W-1:0] a_ext, b_ext;
  logic                    invalid;
  logic                    red_bit;
  logic signed [OUT_W-1:0] op_res_d;
  logic signed [OUT_W-1:0] step_d;
  logic signed [OUT_W-1:0] raw_d;
  logic signed [OUT_W-1:0] out_d;
  logic [LED_W-1:0]        leds_d;

  assign a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};

  assign invalid = (op_q[2:1] == 2'b11) ||
                   ((ra_q || rb_q) && (op_q[2:1] != 2'b00));

  // Reductions act on the raw WIDTH-bit operand, not the sign-extended one.
  always_comb begin
    red_bit = 1'b0;
    if (ra_q && rb_q) begin
      if (PRIO_A) red_bit = op_q[0] ? ^a_q : |a_q;
      else        red_bit = op_q[0] ? ^b_q : |b_q;
    end else if (ra_q) begin
      red_bit = op_q[0] ? ^a_q : |a_q;
    end else begin
      red_bit = op_q[0] ? ^b_q : |b_q;
    end
  end

  always_comb begin
    op_res_d = out_q;
    unique case (op_q)
      3'd0: op_res_d = (ra_q || rb_q) ? OUT_W'(red_bit) : (a_ext | b_ext);
      3'd1: op_res_d = (ra_q || rb_q) ? OUT_W'(red_bit) : (a_ext ^ b_ext);
      3'd2: op_res_d = a_ext + b_ext + OUT_W'(ADD_CI & cin_q);
`ifdef ALSU_PARAM_SERIAL_MULT_EN
      3'd3: op_res_d = '0;
`else
      // Product of the sign-extended operands truncated to OUT_W is exact.
      3'd3: op_res_d = a_ext * b_ext;
`endif
      default: op_res_d = out_q;
    endcase
  end

  always_comb begin
    step_d = out_q;
    if (!op_q[0]) begin
      step_d = dir_q ? {out_q[OUT_W-2:0], sin_q} : {sin_q, out_q[OUT_W-1:1]};
    end else begin
      step_d = dir_q ? {out_q[OUT_W-2:0], out_q[OUT_W-1]}
                     : {out_q[0], out_q[OUT_W-1:1]};
    end
  end

`ifdef ALSU_PARAM_SERIAL_MULT_EN
  // Two's-complement multiplier: the MSB of B carries negative weight, so the
  // final step (counter at zero) subtracts the shifted multiplicand.
  always_comb begin
    mul_sum_d = acc_q;
    if (mplier_q[0]) begin
      mul_sum_d = (cnt_q == '0) ? (acc_q - mcand_q) : (acc_q + mcand_q);
    end
  end
`endif

  always_comb begin
    raw_d = op_res_d;
    if (state_q == ITER) raw_d = step_d;
`ifdef ALSU_PARAM_SERIAL_MULT_EN
    if (state_q == MUL) raw_d = mul_sum_d;
`endif
  end

  always_comb begin
    out_d = raw_d;
    if (ba_q && bb_q)  out_d = PRIO_A ? a_ext : b_ext;
    else if (ba_q)     out_d = a_ext;
    else if (bb_q)     out_d = b_ext;
    else if (invalid)  out_d = '0;
  end

  assign leds_d = invalid ? ~leds_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      sin_q   <= 1'b0;
      dir_q   <= 1'b0;
      ra_q    <= 1'b0;
      rb_q    <= 1'b0;
      ba_q    <= 1'b0;
      bb_q    <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      leds_q  <= '0;
`ifdef ALSU_PARAM_SERIAL_MULT_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            op_q  <= bus.opcode;
            cin_q <= bus.cin;
            sin_q <= bus.serial_in;
            dir_q <= bus.direction;
            ra_q  <= bus.red_op_A;
            rb_q  <= bus.red_op_B;
            ba_q  <= bus.bypass_A;
            bb_q  <= bus.bypass_B;
            cnt_q <= bus.shamt;
`ifdef ALSU_PARAM_SERIAL_MULT_EN
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
            mplier_q <= bus.B;
`endif
            if ((bus.opcode[2:1] == 2'b10) && (bus.shamt != '0)) begin
              state_q <= ITER;
            end
`ifdef ALSU_PARAM_SERIAL_MULT_EN
            else if (bus.opcode == 3'd3) begin
              state_q <= MUL;
              cnt_q   <= SH_W'(WIDTH - 1);
            end
`endif
            else begin
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          out_q   <= out_d;
          vld_q   <= 1'b1;
          leds_q  <= leds_d;
          state_q <= IDLE;
        end
        ITER: begin
          out_q <= out_d;
          cnt_q <= cnt_q - SH_W'(1);
          if (cnt_q == SH_W'(1)) begin
            vld_q   <= 1'b1;
            leds_q  <= leds_d;
            state_q <= IDLE;
          end
        end
`ifdef ALSU_PARAM_SERIAL_MULT_EN
        MUL: begin
          acc_q    <= mul_sum_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - SH_W'(1);
          if (cnt_q == '0) begin
            out_q   <= out_d;
            vld_q   <= 1'b1;
            leds_q  <= leds_d;
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
  assign bus.leds      = leds_q;
endmodule
